// File: rtl/mmio_host_master.sv
// Host-side MMIO initiator: turns one host command into one SoC request/response
// transaction, checks the echoed response, and reports data plus a status code.
module mmio_host_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int TMO_CYCLES = 1024,
  parameter int TMO_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_val,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              req_cmd,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_val,
  input  logic              req_rdy,
  input  logic              resp_cmd,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_val,
  output logic              resp_rdy,
  output logic              busy,
  output logic [7:0]        stale_cnt,
  output logic [7:0]        tmo_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_TMO  = 2'b01;
  localparam logic [1:0] ST_ADDR = 2'b10;
  localparam logic [1:0] ST_CMD  = 2'b11;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic              req_val_q, req_val_d;
  logic              req_cmd_q, req_cmd_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              rsp_val_q, rsp_val_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [7:0]        stale_cnt_q, stale_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;

  logic tmo_hit, tmo_evt, stale_evt;

  // A handshake in the same cycle as the timer expiring always wins over the timeout.
  assign tmo_hit   = (timer_q == TMO_LAST);
  assign tmo_evt   = tmo_hit && (((state_q == S_REQ) && !req_rdy) ||
                                 ((state_q == S_WAIT) && !resp_val));
  assign stale_evt = resp_val && resp_rdy &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      req_val_q    <= 1'b0;
      req_cmd_q    <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      rsp_val_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      stale_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      req_val_q    <= req_val_d;
      req_cmd_q    <= req_cmd_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      rsp_val_q    <= rsp_val_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      stale_cnt_q  <= stale_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_val && cmd_rdy) state_d = S_REQ;
      S_REQ:  if (req_val_q && req_rdy) state_d = S_WAIT;
              else if (tmo_hit)        state_d = S_DONE;
      S_WAIT: if (resp_val || tmo_hit) state_d = S_DONE;
      S_DONE: if (rsp_val_q && rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy  = 1'b0;
    resp_rdy = 1'b1;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  cmd_rdy  = 1'b1;
      S_REQ:   resp_rdy = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    timer_d      = timer_q;
    req_val_d    = req_val_q;
    req_cmd_d    = req_cmd_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    rsp_val_d    = rsp_val_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    stale_cnt_d  = stale_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      S_IDLE: if (cmd_val && cmd_rdy) begin
        req_cmd_d  = cmd_wr;
        req_addr_d = cmd_addr;
        req_data_d = cmd_data;
        req_val_d  = 1'b1;
        timer_d    = '0;
      end
      S_REQ: if (req_val_q && req_rdy) begin
        req_val_d = 1'b0;
        timer_d   = '0;
      end else if (tmo_hit) begin
        req_val_d    = 1'b0;
        rsp_status_d = ST_TMO;
        rsp_data_d   = '0;
        rsp_val_d    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      S_WAIT: if (resp_val) begin
        rsp_data_d = resp_data;
        rsp_val_d  = 1'b1;
        if (resp_addr != req_addr_q)    rsp_status_d = ST_ADDR;
        else if (resp_cmd != req_cmd_q) rsp_status_d = ST_CMD;
        else                            rsp_status_d = ST_OK;
      end else if (tmo_hit) begin
        rsp_status_d = ST_TMO;
        rsp_data_d   = '0;
        rsp_val_d    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      S_DONE: if (rsp_val_q && rsp_rdy) rsp_val_d = 1'b0;
      default: ;
    endcase
    if (stale_evt && (stale_cnt_q != 8'hFF)) stale_cnt_d = stale_cnt_q + 8'd1;
    if (tmo_evt && (tmo_cnt_q != 8'hFF))     tmo_cnt_d   = tmo_cnt_q + 8'd1;
  end

  assign req_val    = req_val_q;
  assign req_cmd    = req_cmd_q;
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign rsp_val    = rsp_val_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign stale_cnt  = stale_cnt_q;
  assign tmo_cnt    = tmo_cnt_q;

endmodule

// File: tb/tb_mmio_host_master.sv
// Directed bench for mmio_host_master: the stimulus thread also plays the SoC side,
// while a monitor pops expected results from a scoreboard queue on every rsp handshake.
module tb_mmio_host_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_val = 1'b0, cmd_rdy, cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_val, rsp_rdy = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              req_cmd, req_val, req_rdy = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_cmd = 1'b0, resp_val = 1'b0, resp_rdy;
  logic [ADDR_W-1:0] resp_addr = '0;
  logic [DATA_W-1:0] resp_data = '0;
  logic              busy;
  logic [7:0]        stale_cnt, tmo_cnt;

  mmio_host_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYCLES(TMO), .TMO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .req_val(req_val), .req_rdy(req_rdy),
    .resp_cmd(resp_cmd), .resp_addr(resp_addr), .resp_data(resp_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .busy(busy), .stale_cnt(stale_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        status;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each host-side result handshake consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_val && rsp_rdy) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rsp: got status %0d data 0x%0h, expected no result",
                 rsp_status, rsp_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_status", 64'(rsp_status), 64'(e.status));
        checkOutput("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCmdRdy();
    int n = 0;
    while (!cmd_rdy && n < 64) begin
      step();
      n++;
    end
    checkOutput("cmd_rdy_wait", 64'(cmd_rdy), 64'd1);
  endtask

  // rdyDelay < 0 keeps req_rdy low through the request timeout; respLat < 0 withholds the response.
  task automatic applyStimulus(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data,
    input int                rdyDelay,
    input int                respLat,
    input logic [ADDR_W-1:0] respAddr,
    input logic              respCmd,
    input logic [DATA_W-1:0] respData,
    input logic [1:0]        expStatus,
    input logic [DATA_W-1:0] expData,
    input bit                pushExp
  );
    exp_t e;
    waitCmdRdy();
    cmd_val  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = addr;
    cmd_data = data;
    if (pushExp) begin
      e.data   = expData;
      e.status = expStatus;
      expQ.push_back(e);
    end
    step();
    cmd_val = 1'b0;
    checkOutput("req_cmd", 64'(req_cmd), 64'(wr));
    checkOutput("req_addr", 64'(req_addr), 64'(addr));
    checkOutput("req_data", req_data, data);
    if (rdyDelay < 0) begin
      for (int i = 0; i < TMO; i++) begin
        checkOutput("req_val_hold_tmo", 64'(req_val), 64'd1);
        step();
      end
      checkOutput("req_val_abort", 64'(req_val), 64'd0);
      return;
    end
    for (int i = 0; i < rdyDelay; i++) begin
      checkOutput("req_val_stall", 64'(req_val), 64'd1);
      checkOutput("req_addr_stall", 64'(req_addr), 64'(addr));
      step();
    end
    checkOutput("req_val_pre_hs", 64'(req_val), 64'd1);
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    checkOutput("req_val_post_hs", 64'(req_val), 64'd0);
    if (respLat < 0) return;
    repeat (respLat) step();
    resp_val  = 1'b1;
    resp_cmd  = respCmd;
    resp_addr = respAddr;
    resp_data = respData;
    step();
    resp_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_rdy", 64'(cmd_rdy), 64'd1);
    checkOutput("reset_req_val", 64'(req_val), 64'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_resp_rdy", 64'(resp_rdy), 64'd1);
    checkOutput("idle_rsp_val", 64'(rsp_val), 64'd0);
    checkOutput("idle_counters", 64'({stale_cnt, tmo_cnt}), 64'd0);

    $display("[TB] back-to-back write/read");
    applyStimulus(1'b1, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 0, 3,
                  32'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b1);
    applyStimulus(1'b0, 32'h8000_0010, 64'h0, 0, 3,
                  32'h8000_0010, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b1);

    $display("[TB] stalled req_rdy");
    applyStimulus(1'b1, 32'h4000_0000, 64'h55, 5, 2,
                  32'h4000_0000, 1'b1, 64'h55, 2'b00, 64'h55, 1'b1);

    $display("[TB] request timeout");
    applyStimulus(1'b1, 32'h8000_0020, 64'h77, -1, -1,
                  32'h0, 1'b0, 64'h0, 2'b01, 64'h0, 1'b1);
    waitCmdRdy();
    checkOutput("tmo_cnt_req", 64'(tmo_cnt), 64'd1);

    $display("[TB] late response");
    rsp_rdy = 1'b0;
    applyStimulus(1'b0, 32'h0000_0100, 64'h0, 0, -1,
                  32'h0, 1'b0, 64'h0, 2'b01, 64'h0, 1'b1);
    n = 0;
    while (!rsp_val && n < 64) begin
      step();
      n++;
    end
    checkOutput("rsp_val_wait", 64'(rsp_val), 64'd1);
    checkOutput("done_resp_rdy", 64'(resp_rdy), 64'd1);
    resp_val  = 1'b1;
    resp_cmd  = 1'b0;
    resp_addr = 32'h0000_0100;
    resp_data = 64'hBAD;
    step();
    resp_val = 1'b0;
    checkOutput("stale_cnt_late", 64'(stale_cnt), 64'd1);
    checkOutput("tmo_cnt_wait", 64'(tmo_cnt), 64'd2);
    checkOutput("done_hold_status", 64'(rsp_status), 64'd1);
    checkOutput("done_hold_data", rsp_data, 64'd0);
    rsp_rdy = 1'b1;
    applyStimulus(1'b0, 32'h0000_0100, 64'h0, 1, 1,
                  32'h0000_0100, 1'b0, 64'hCAFE, 2'b00, 64'hCAFE, 1'b1);

    $display("[TB] mismatches");
    applyStimulus(1'b0, 32'h8000_0010, 64'h0, 0, 2,
                  32'h8000_0018, 1'b0, 64'h1111, 2'b10, 64'h1111, 1'b1);
    applyStimulus(1'b1, 32'h8000_0010, 64'h2222, 0, 2,
                  32'h8000_0010, 1'b0, 64'h2222, 2'b11, 64'h2222, 1'b1);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 32'h8000_0030, 64'h3333, 0, -1,
                  32'h0, 1'b0, 64'h0, 2'b00, 64'h0, 1'b0);
    checkOutput("wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_req", 64'({req_val, req_cmd, req_addr}), 64'd0);
    checkOutput("rst_req_data", req_data, 64'd0);
    checkOutput("rst_rsp", 64'({rsp_val, rsp_status}), 64'd0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    checkOutput("rst_counters", 64'({stale_cnt, tmo_cnt}), 64'd0);
    repeat (TMO + 4) step();
    checkOutput("no_rsp_after_rst", 64'(rsp_val), 64'd0);

    applyStimulus(1'b0, 32'h8000_0040, 64'h0, 2, 1,
                  32'h8000_0040, 1'b0, 64'h4444, 2'b00, 64'h4444, 1'b1);
    waitCmdRdy();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
